// File: rtl/slot_pkg.sv
// slot_pkg: shared slot window boundaries for the 198-count frame.
// Used by both the sweep generator and the count-to-slot decoder.
package slot_pkg;

    localparam int NUM_SLOTS = 16;
    localparam int FRAME_LEN = 198;
    localparam int CNT_W     = 8;
    localparam int IDX_W     = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t SLOT_START [NUM_SLOTS] = '{
        8'd0,   8'd13,  8'd26,  8'd39,
        8'd52,  8'd65,  8'd78,  8'd91,
        8'd104, 8'd117, 8'd130, 8'd143,
        8'd156, 8'd169, 8'd172, 8'd185
    };

    localparam cnt_t SLOT_END [NUM_SLOTS] = '{
        8'd12,  8'd25,  8'd38,  8'd51,
        8'd64,  8'd77,  8'd90,  8'd103,
        8'd116, 8'd129, 8'd142, 8'd155,
        8'd168, 8'd171, 8'd184, 8'd197
    };

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    // Forward direction: which slot window a count falls in.
    function automatic logic [IDX_W-1:0] count_to_slot(input cnt_t c);
        logic [IDX_W-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (c >= SLOT_START[i]) begin
                s = IDX_W'(i);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/slot_window_lut.sv
// slot_window_lut: slot address to inclusive {start, end} window.
// in_range is low for addresses beyond the last slot.
module slot_window_lut #(
    parameter int COUNT_W = 8,
    parameter int ADDR_W  = 5
) (
    input  logic [ADDR_W-1:0]  slot,
    output logic [COUNT_W-1:0] win_start,
    output logic [COUNT_W-1:0] win_end,
    output logic               in_range
);

    import slot_pkg::*;

    logic [IDX_W-1:0] idx;

    // Table lookup; index is only meaningful when in_range is set.
    always_comb begin
        idx       = slot[IDX_W-1:0];
        in_range  = (32'(slot) < 32'(NUM_SLOTS));
        win_start = COUNT_W'(SLOT_START[idx]);
        win_end   = COUNT_W'(SLOT_END[idx]);
    end

endmodule

// File: rtl/slot_sweep.sv
// slot_sweep: accepts a slot request and streams every count of
// that slot's window, one beat per cycle, under backpressure.
module slot_sweep #(
    parameter int COUNT_W = 8,
    parameter int ADDR_W  = 5
) (
    input  logic               sysclk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [ADDR_W-1:0]  req_slot,
    output logic               req_ready,
    output logic [COUNT_W-1:0] count,
    output logic               count_valid,
    input  logic               count_ready,
    output logic               last,
    output logic               busy,
    output logic               err
);

    import slot_pkg::*;

    state_t             state;
    state_t             state_nxt;
    logic [COUNT_W-1:0] win_start;
    logic [COUNT_W-1:0] win_end;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] end_q;
    logic               in_range;
    logic               take;
    logic               bad;
    logic               at_end;

    slot_window_lut #(
        .COUNT_W (COUNT_W),
        .ADDR_W  (ADDR_W)
    ) u_lut (
        .slot      (req_slot),
        .win_start (win_start),
        .win_end   (win_end),
        .in_range  (in_range)
    );

    assign take   = (state == IDLE) && req_valid && in_range;
    assign bad    = (state == IDLE) && req_valid && !in_range;
    assign at_end = (count_q == end_q);
    assign count  = count_q;

    // State register; reset aborts any sweep in progress.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: start on a good request, stop once the end beat is taken.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (take) begin
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                if (count_ready && at_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state and the window position.
    always_comb begin
        req_ready   = (state == IDLE);
        busy        = (state == SWEEP);
        count_valid = (state == SWEEP);
        last        = (state == SWEEP) && at_end;
    end

    // Window latch, counter and error pulse; a held bad request
    // re-pulses err every other cycle because the pulse gates itself.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            end_q   <= '0;
            err     <= 1'b0;
        end else begin
            err <= bad && !err;
            if (take) begin
                count_q <= win_start;
                end_q   <= win_end;
            end else if (state == SWEEP && count_ready && !at_end) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_slot_sweep.sv
// tb_slot_sweep: scoreboard bench for slot_sweep.
// Expected beats are queued on request and checked as they are consumed.
module tb_slot_sweep;

    localparam int COUNT_W = 8;
    localparam int ADDR_W  = 5;

    logic               sysclk = 1'b0;
    logic               rst_n;
    logic               req_valid;
    logic [ADDR_W-1:0]  req_slot;
    logic               req_ready;
    logic [COUNT_W-1:0] count;
    logic               count_valid;
    logic               count_ready;
    logic               last;
    logic               busy;
    logic               err;

    typedef struct packed {
        logic [COUNT_W-1:0] c;
        logic               l;
    } beat_t;

    beat_t exp_q [$];
    beat_t mon_exp;
    int    vectors     = 0;
    int    miscompares = 0;

    slot_sweep #(
        .COUNT_W (COUNT_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_slot    (req_slot),
        .req_ready   (req_ready),
        .count       (count),
        .count_valid (count_valid),
        .count_ready (count_ready),
        .last        (last),
        .busy        (busy),
        .err         (err)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #500000;
        $display("FAIL watchdog: run still active, required finish");
        $fatal(1);
    end

    function automatic int win_lo(input int s);
        if (s < 13) return 13 * s;
        if (s == 13) return 169;
        if (s == 14) return 172;
        return 185;
    endfunction

    function automatic int win_hi(input int s);
        if (s < 13) return 13 * s + 12;
        if (s == 13) return 171;
        if (s == 14) return 184;
        return 197;
    endfunction

    task automatic push_window(input int s);
        beat_t b;
        for (int v = win_lo(s); v <= win_hi(s); v++) begin
            b.c = COUNT_W'(v);
            b.l = (v == win_hi(s));
            exp_q.push_back(b);
        end
    endtask

    // Present a request for exactly one edge; returns just after that edge.
    task automatic issue(input int s);
        @(posedge sysclk);
        #1;
        req_valid = 1'b1;
        req_slot  = ADDR_W'(s);
        if (s < 16) push_window(s);
        @(posedge sysclk);
        #1;
        req_valid = 1'b0;
    endtask

    // Consumed beats are popped from the scoreboard and compared.
    always @(negedge sysclk) begin
        if (rst_n && count_valid && count_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL beat_extra: count=%0d last=%b, required no beat",
                         count, last);
            end else begin
                mon_exp = exp_q.pop_front();
                if (count !== mon_exp.c || last !== mon_exp.l) begin
                    miscompares++;
                    $display("FAIL beat: count=%0d last=%b, required count=%0d last=%b",
                             count, last, mon_exp.c, mon_exp.l);
                end
            end
        end
    end

    task automatic test_reset;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_slot    = '0;
        count_ready = 1'b1;
        @(negedge sysclk);
        vectors++;
        if ({req_ready, count_valid, last, busy, err, count}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL reset_values: rdy,vld,last,busy,err,count=%b,%b,%b,%b,%b,%0d required 1,0,0,0,0,0",
                     req_ready, count_valid, last, busy, err, count);
        end
        @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
    endtask

    task automatic test_slot0;
        issue(0);
        for (int i = 0; i < 13; i++) begin
            @(negedge sysclk);
            vectors++;
            if (count_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL slot0_beat%0d: vld=%b busy=%b rdy=%b, required 1 1 0",
                         i, count_valid, busy, req_ready);
            end
        end
        @(negedge sysclk);
        vectors++;
        if (req_ready !== 1'b1 || count_valid !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL slot0_done: rdy=%b vld=%b left=%0d, required 1 0 0",
                     req_ready, count_valid, exp_q.size());
        end
    endtask

    task automatic test_slot13;
        issue(13);
        for (int i = 0; i < 2; i++) begin
            @(negedge sysclk);
            vectors++;
            if (count_valid !== 1'b1 || last !== 1'b0) begin
                miscompares++;
                $display("FAIL slot13_beat%0d: vld=%b last=%b, required 1 0",
                         i, count_valid, last);
            end
        end
        @(posedge sysclk);
        #1;
        count_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge sysclk);
            vectors++;
            if (count !== 8'd171 || last !== 1'b1 || count_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL slot13_last_hold: count=%0d last=%b vld=%b, required 171 1 1",
                         count, last, count_valid);
            end
        end
        @(posedge sysclk);
        #1;
        count_ready = 1'b1;
        @(negedge sysclk);
        @(negedge sysclk);
        vectors++;
        if (req_ready !== 1'b1 || count_valid !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL slot13_done: rdy=%b vld=%b left=%0d, required 1 0 0",
                     req_ready, count_valid, exp_q.size());
        end
    endtask

    task automatic test_bad_slot;
        logic e;
        issue(20);
        @(negedge sysclk);
        vectors++;
        if (err !== 1'b1 || count_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_pulse: err=%b vld=%b rdy=%b, required 1 0 1",
                     err, count_valid, req_ready);
        end
        @(negedge sysclk);
        vectors++;
        if (err !== 1'b0 || count_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_clear: err=%b vld=%b, required 0 0", err, count_valid);
        end
        @(posedge sysclk);
        #1;
        req_valid = 1'b1;
        req_slot  = 5'd31;
        for (int i = 0; i < 6; i++) begin
            @(negedge sysclk);
            e = ((i % 2) == 1);
            vectors++;
            if (err !== e || count_valid !== 1'b0 || req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL bad_held%0d: err=%b vld=%b rdy=%b, required %b 0 1",
                         i, err, count_valid, req_ready, e);
            end
        end
        @(posedge sysclk);
        #1;
        req_valid = 1'b0;
        @(negedge sysclk);
        @(negedge sysclk);
        vectors++;
        if (err !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL bad_end: err=%b left=%0d, required 0 0", err, exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        issue(1);
        @(negedge sysclk);
        @(negedge sysclk);
        @(posedge sysclk);
        #1;
        count_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            vectors++;
            if (count !== 8'd15 || count_valid !== 1'b1 || last !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: count=%0d vld=%b last=%b, required 15 1 0",
                         i, count, count_valid, last);
            end
        end
        @(posedge sysclk);
        #1;
        count_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge sysclk);
            vectors++;
            if (count_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_resume%0d: vld=%b, required 1", i, count_valid);
            end
        end
        @(negedge sysclk);
        vectors++;
        if (req_ready !== 1'b1 || count_valid !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_done: rdy=%b vld=%b left=%0d, required 1 0 0",
                     req_ready, count_valid, exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        issue(14);
        for (int i = 0; i < 6; i++) @(negedge sysclk);
        @(negedge sysclk);
        vectors++;
        if (count !== 8'd178 || count_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_pos: count=%0d vld=%b, required 178 1",
                     count, count_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({req_ready, count_valid, last, busy, err, count}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL rst_mid_async: rdy,vld,last,busy,err,count=%b,%b,%b,%b,%b,%0d required 1,0,0,0,0,0",
                     req_ready, count_valid, last, busy, err, count);
        end
        exp_q.delete();
        @(negedge sysclk);
        @(negedge sysclk);
        rst_n = 1'b1;
        issue(14);
        for (int i = 0; i < 13; i++) begin
            @(negedge sysclk);
            vectors++;
            if (count_valid !== 1'b1 || (i == 0 && count !== 8'd172)) begin
                miscompares++;
                $display("FAIL rst_restart%0d: vld=%b count=%0d, required valid (first 172)",
                         i, count_valid, count);
            end
        end
        @(negedge sysclk);
        vectors++;
        if (req_ready !== 1'b1 || count_valid !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_restart_done: rdy=%b vld=%b left=%0d, required 1 0 0",
                     req_ready, count_valid, exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        @(posedge sysclk);
        #1;
        req_valid = 1'b1;
        req_slot  = 5'd2;
        push_window(2);
        @(posedge sysclk);
        #1;
        req_slot = 5'd5;
        push_window(5);
        for (int i = 0; i < 13; i++) begin
            @(negedge sysclk);
            vectors++;
            if (count_valid !== 1'b1 || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_first%0d: vld=%b rdy=%b, required 1 0",
                         i, count_valid, req_ready);
            end
        end
        @(negedge sysclk);
        vectors++;
        if (req_ready !== 1'b1 || count_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap: rdy=%b vld=%b, required 1 0", req_ready, count_valid);
        end
        @(posedge sysclk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(negedge sysclk);
            vectors++;
            if (count_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_second%0d: vld=%b, required 1", i, count_valid);
            end
        end
        @(negedge sysclk);
        vectors++;
        if (req_ready !== 1'b1 || count_valid !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_done: rdy=%b vld=%b left=%0d, required 1 0 0",
                     req_ready, count_valid, exp_q.size());
        end
    endtask

    task automatic test_all_slots;
        int len;
        for (int s = 0; s < 16; s++) begin
            issue(s);
            len = win_hi(s) - win_lo(s) + 1;
            for (int i = 0; i < len; i++) begin
                @(negedge sysclk);
                vectors++;
                if (count_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL all_slot%0d_beat%0d: vld=%b, required 1",
                             s, i, count_valid);
                end
            end
            @(negedge sysclk);
            vectors++;
            if (count_valid !== 1'b0 || exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL all_slot%0d_done: vld=%b left=%0d, required 0 0",
                         s, count_valid, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    initial begin
        test_reset();
        test_slot0();
        test_slot13();
        test_bad_slot();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_all_slots();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
